// File: rtl/wb_retire_stage_pkg.sv
// Shared widths and bus field offsets for the writeback retire stage.
// Bus layout, MSB first: {gr_we, dest, result, pc}.
package wb_retire_stage_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 32;

    function automatic int bus_wd(int ra, int dw, int pw);
        return 1 + ra + dw + pw;
    endfunction

    function automatic int res_lsb(int pw);
        return pw;
    endfunction

    function automatic int dest_lsb(int dw, int pw);
        return pw + dw;
    endfunction

    function automatic int we_bit(int ra, int dw, int pw);
        return pw + dw + ra;
    endfunction

    localparam int MS_TO_WS_BUS_WD = bus_wd(REG_AW_DEF, DATA_W_DEF, PC_W_DEF);

endpackage

// File: rtl/wb_retire_fifo.sv
// Pointer/count retire queue with a flat read-out of all entries.
// Flush empties the queue by moving head onto tail.
module wb_retire_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [W-1:0]         wdata,
    output logic [W-1:0]         head_ent,
    output logic [DEPTH*W-1:0]   entries,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] tail;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset; validity lives in count.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= wdata;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign entries[g*W +: W] = mem[g];
    end

    assign head_ent = mem[head];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback stage: retire queue, youngest-first forwarding, RF/trace retire.
// WB_DEBUG_TRACE_EN adds the debug_wb_* trace ports.
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int DEPTH   = 2,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      ws_stall,
    input  logic                      ws_flush,
    output logic                      ws_allowin,
    input  logic                      ms_to_ws_valid,
    input  logic [1+REG_AW+DATA_W+PC_W-1:0] ms_to_ws_bus,
    input  logic                      rf_wr_ready,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_raddr,
    output logic [NUM_FWD-1:0]        fwd_hit,
    output logic [NUM_FWD*DATA_W-1:0] fwd_data
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [PC_W-1:0]           debug_wb_pc,
    output logic [3:0]                debug_wb_rf_we,
    output logic [REG_AW-1:0]         debug_wb_rf_wnum,
    output logic [DATA_W-1:0]         debug_wb_rf_wdata
`endif
);

    localparam int BUS_W = bus_wd(REG_AW, DATA_W, PC_W);
`ifdef WB_DEBUG_TRACE_EN
    localparam int PS = PC_W;
`else
    localparam int PS = 0;
`endif
    // Stored entry drops pc when no trace is built.
    localparam int ENT_W    = BUS_W - PC_W + PS;
    localparam int RES_LSB  = res_lsb(PS);
    localparam int DEST_LSB = dest_lsb(DATA_W, PS);
    localparam int WE_BIT   = we_bit(REG_AW, DATA_W, PS);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;

    logic [ENT_W-1:0]       ent_in;
    logic [ENT_W-1:0]       head_ent;
    logic [DEPTH*ENT_W-1:0] entries;
    logic [AW-1:0]          head;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;

    assign ent_in = ms_to_ws_bus[BUS_W-1 -: ENT_W];

`ifndef WB_DEBUG_TRACE_EN
    logic [PC_W-1:0] unused_pc;
    assign unused_pc = ms_to_ws_bus[PC_W-1:0];
`endif

    assign pop        = !empty && rf_wr_ready && !ws_flush;
    assign ws_allowin = (!full || pop) && !ws_stall && !ws_flush;
    assign push       = ms_to_ws_valid && ws_allowin;

    wb_retire_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .pop      (pop),
        .flush    (ws_flush),
        .wdata    (ent_in),
        .head_ent (head_ent),
        .entries  (entries),
        .head     (head),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    assign rf_we    = pop && head_ent[WE_BIT];
    assign rf_waddr = head_ent[DEST_LSB +: REG_AW];
    assign rf_wdata = head_ent[RES_LSB +: DATA_W];

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = head_ent[PC_W-1:0];
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

    // Walk oldest to youngest so the youngest match is the last writer.
    always_comb begin
        logic [AW-1:0]     idx;
        logic [ENT_W-1:0]  e;
        logic [REG_AW-1:0] ra;
        idx      = '0;
        e        = '0;
        ra       = '0;
        fwd_hit  = '0;
        fwd_data = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            ra = fwd_raddr[i*REG_AW +: REG_AW];
            for (int k = 0; k < DEPTH; k++) begin
                idx = head + AW'(k);
                e   = entries[idx*ENT_W +: ENT_W];
                if (CW'(k) < count && e[WE_BIT] &&
                    e[DEST_LSB +: REG_AW] == ra && ra != '0) begin
                    fwd_hit[i] = 1'b1;
                    fwd_data[i*DATA_W +: DATA_W] = e[RES_LSB +: DATA_W];
                end
            end
        end
    end

endmodule
